// File: rtl/mem_store_pkg.sv
// Shared encodings for the store sequencer: request sizes, FSM states and
// the size-to-byte-count helper used by the top and the lane selector.
package mem_store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_e;

  // Number of bytes a request writes; zero for the reserved encoding.
  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    logic [2:0] cnt;
    case (size)
      SZ_BYTE: cnt = 3'd1;
      SZ_HALF: cnt = 3'd2;
      SZ_WORD: cnt = 3'd4;
      default: cnt = 3'd0;
    endcase
    return cnt;
  endfunction

  // A request is legal when its size is defined and its address is
  // naturally aligned to that size.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_lane_sel.sv
// Big-endian byte lane selector: for a store of n bytes, write k (0-based)
// carries data byte (n-1-k), where byte 0 is data[7:0].
module store_lane_sel
  import mem_store_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        n,
  input  logic [1:0]        k,
  output logic [BYTE_W-1:0] byte_o
);

  logic [1:0] lane;

  // Lane index n-1-k; only meaningful for legal (n, k) pairs.
  always_comb begin
    lane = 2'(n - {1'b0, k} - 3'd1);
  end

  // Pick the addressed byte of the store data.
  always_comb begin
    case (lane)
      2'd0:    byte_o = data[7:0];
      2'd1:    byte_o = data[15:8];
      2'd2:    byte_o = data[23:16];
      default: byte_o = data[31:24];
    endcase
  end

endmodule

// File: rtl/mem_store_sequencer.sv
// Store sequencer: accepts one store request (address, 32-bit data, size)
// and serialises it into consecutive big-endian byte writes on an 8-bit
// byte-addressed RAM port, then pulses done (or err for an illegal request).
// All outputs are registered so the RAM port sees clean strobes.
module mem_store_sequencer
  import mem_store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ready_q, ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BYTE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic                last_byte;
  logic [1:0]          k_next;
  logic [DATA_W-1:0]   lane_data;
  logic [2:0]          lane_cnt;
  logic [1:0]          lane_k;
  logic [BYTE_W-1:0]   lane_byte;

  assign accept    = req_valid && ready_q;
  assign k_next    = k_q + 2'd1;
  assign last_byte = ({1'b0, k_q} == (cnt_q - 3'd1));

  // Lane selector input: the first byte comes straight from the request at
  // accept time, later bytes from the captured request.
  always_comb begin
    lane_data = data_q;
    lane_cnt  = cnt_q;
    lane_k    = k_next;
    if (state_q == IDLE) begin
      lane_data = req_data;
      lane_cnt  = size_to_count(req_size);
      lane_k    = 2'd0;
    end
  end

  store_lane_sel u_lane_sel (
    .data   (lane_data),
    .n      (lane_cnt),
    .k      (lane_k),
    .byte_o (lane_byte)
  );

  // Next-state and next-output logic of the sequencer FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_legal(req_size, req_addr[1:0])) begin
            state_d     = WRITE;
            k_d         = 2'd0;
            cnt_d       = size_to_count(req_size);
            addr_d      = req_addr;
            data_d      = req_data;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_addr;
            mem_wdata_d = lane_byte;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      WRITE: begin
        if (last_byte) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          k_d         = k_next;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q + {{(ADDR_W-2){1'b0}}, k_next};
          mem_wdata_d = lane_byte;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!Reset) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
